// File: rtl/gcd_pkg.sv
// Shared definitions for the fraction-reduction stage behind the GCD calculator.
package gcd_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_MUL  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  localparam int unsigned DEFAULT_W = 8;

  // Bits needed to hold a count of 0..v-1 (never less than one bit).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/gcd_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module gcd_div_step #(
  parameter int unsigned W = 8
) (
  input  logic [W:0]   rem,
  input  logic         din,
  input  logic [W-1:0] divisor,
  output logic [W:0]   rem_nx,
  output logic         q_bit
);

  logic [W+1:0] sh;

  always_comb begin
    sh     = {rem, din};
    q_bit  = (sh >= {2'b00, divisor});
    rem_nx = q_bit ? (W+1)'(sh - {2'b00, divisor}) : (W+1)'(sh);
  end

endmodule

// File: rtl/gcd_frac_reduce.sv
// Reduces num/den by a supplied gcd and forms the LCM with a serial divider and multiplier.
module gcd_frac_reduce
  import gcd_pkg::*;
#(
  parameter int unsigned W = DEFAULT_W
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_num,
  input  logic [W-1:0]   in_den,
  input  logic [W-1:0]   in_gcd,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_num,
  output logic [W-1:0]   out_den,
  output logic [2*W-1:0] out_lcm,
  output logic           out_err
);

  localparam int unsigned CW = clog2(W);

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    a_sh, b_sh, g_q, den_q, q_a, q_b, mplier;
  logic [W:0]      rem_a, rem_b, rem_a_nx, rem_b_nx;
  logic            qa_bit, qb_bit, err_q, cnt_zero, g_zero, accept;
  logic [2*W-1:0]  mcand, acc, sum;
  logic [W-1:0]    q_a_nx, q_b_nx;

  gcd_div_step #(.W(W)) u_div_num (
    .rem(rem_a), .din(a_sh[W-1]), .divisor(g_q), .rem_nx(rem_a_nx), .q_bit(qa_bit)
  );

  gcd_div_step #(.W(W)) u_div_den (
    .rem(rem_b), .din(b_sh[W-1]), .divisor(g_q), .rem_nx(rem_b_nx), .q_bit(qb_bit)
  );

  assign in_ready  = (state == S_IDLE) && !reset;
  assign out_valid = (state == S_OUT);
  assign accept    = in_valid && in_ready;
  assign cnt_zero  = (cnt == '0);
  assign g_zero    = (g_q == '0);
  assign q_a_nx    = (q_a << 1) | W'(qa_bit);
  assign q_b_nx    = (q_b << 1) | W'(qb_bit);
  assign sum       = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept)    state_nx = S_DIV;
      S_DIV:  if (cnt_zero)  state_nx = S_MUL;
      S_MUL:  if (cnt_zero)  state_nx = S_OUT;
      S_OUT:  if (out_ready) state_nx = S_IDLE;
      default:               state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      g_q     <= '0;
      den_q   <= '0;
      rem_a   <= '0;
      rem_b   <= '0;
      q_a     <= '0;
      q_b     <= '0;
      err_q   <= 1'b0;
      mplier  <= '0;
      mcand   <= '0;
      acc     <= '0;
      out_num <= '0;
      out_den <= '0;
      out_lcm <= '0;
      out_err <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (accept) begin
            a_sh  <= in_num;
            b_sh  <= in_den;
            g_q   <= in_gcd;
            den_q <= in_den;
            rem_a <= '0;
            rem_b <= '0;
            q_a   <= '0;
            q_b   <= '0;
            err_q <= (in_gcd == '0);
            cnt   <= CW'(W - 1);
          end
        end
        S_DIV: begin
          cnt  <= cnt - 1'b1;
          a_sh <= a_sh << 1;
          b_sh <= b_sh << 1;
          // Zero divisor keeps quotients at 0 but still spends W cycles for fixed latency.
          if (!g_zero) begin
            rem_a <= rem_a_nx;
            rem_b <= rem_b_nx;
            q_a   <= q_a_nx;
            q_b   <= q_b_nx;
          end
          if (cnt_zero) begin
            cnt    <= CW'(W - 1);
            err_q  <= err_q | (!g_zero && ((rem_a_nx != '0) || (rem_b_nx != '0)));
            mplier <= g_zero ? '0 : q_a_nx;
            mcand  <= {{W{1'b0}}, den_q};
            acc    <= '0;
          end
        end
        S_MUL: begin
          cnt    <= cnt - 1'b1;
          acc    <= sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (cnt_zero) begin
            out_num <= q_a;
            out_den <= q_b;
            out_lcm <= sum;
            out_err <= err_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_frac_reduce.sv
// Randomised and directed checks of gcd_frac_reduce against an arithmetic reference model.
module tb_gcd_frac_reduce;

  localparam int unsigned W = 8;

  typedef struct {
    logic [W-1:0]   n;
    logic [W-1:0]   d;
    logic [2*W-1:0] l;
    logic           e;
  } exp_t;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_num = '0, in_den = '0, in_gcd = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [W-1:0]   out_num, out_den;
  logic [2*W-1:0] out_lcm;
  logic           out_err;

  int   tests = 0;
  int   fails = 0;
  exp_t q[$];

  gcd_frac_reduce #(.W(W)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_num(in_num), .in_den(in_den), .in_gcd(in_gcd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_num(out_num), .out_den(out_den), .out_lcm(out_lcm), .out_err(out_err)
  );

  always #5 clock = ~clock;

  function automatic exp_t model(input int unsigned a, input int unsigned b, input int unsigned g);
    exp_t r;
    if (g == 0) begin
      r.n = '0; r.d = '0; r.l = '0; r.e = 1'b1;
    end else begin
      r.n = W'(a / g);
      r.d = W'(b / g);
      r.l = (2*W)'((a / g) * b);
      r.e = ((a % g) != 0) || ((b % g) != 0);
    end
    return r;
  endfunction

  function automatic int unsigned true_gcd(input int unsigned a, input int unsigned b);
    int unsigned x, y, t;
    x = a; y = b;
    while (y != 0) begin
      t = x % y; x = y; y = t;
    end
    return x;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Result checker: whenever a result is presented it must match the oldest pending triple.
  always @(negedge clock) begin
    if (!reset && out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_out_valid", 64'(out_valid), 64'd0);
      end else begin
        chk("out_num", 64'(out_num), 64'(q[0].n));
        chk("out_den", 64'(out_den), 64'(q[0].d));
        chk("out_lcm", 64'(out_lcm), 64'(q[0].l));
        chk("out_err", 64'(out_err), 64'(q[0].e));
        chk("in_ready_in_out", 64'(in_ready), 64'd0);
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  task automatic start(input int unsigned a, input int unsigned b, input int unsigned g);
    int n;
    n = 0;
    while (!in_ready && n < 60) begin
      @(posedge clock); #1; n++;
    end
    if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_num = W'(a); in_den = W'(b); in_gcd = W'(g);
    @(posedge clock);
    q.push_back(model(a, b, g));
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input int unsigned a, input int unsigned b, input int unsigned g,
                      input int unsigned hold);
    int n;
    start(a, b, g);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clock); #1; n++;
    end
    // Accepting edge plus 2W more edges: the 17th edge counted from the accept.
    chk("latency_edges", 64'(n), 64'(2*W));
    if (hold > 0) begin
      out_ready = 1'b0;
      for (int unsigned i = 0; i < hold; i++) begin
        in_valid = 1'($urandom);
        in_num = W'($urandom); in_den = W'($urandom); in_gcd = W'($urandom);
        @(posedge clock); #1;
        chk("hold_in_ready", 64'(in_ready), 64'd0);
        chk("hold_out_valid", 64'(out_valid), 64'd1);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clock); #1;
    chk("released_valid", 64'(out_valid), 64'd0);
    chk("released_in_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic reset_after(input int unsigned edges);
    repeat (edges) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_outs", {out_num, out_den, out_lcm, 7'd0, out_err}, 64'd0);
    q.delete();
    reset = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t m;
    int unsigned a, b, g, r;

    repeat (2) @(posedge clock);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_outs", {out_num, out_den, out_lcm, 7'd0, out_err}, 64'd0);
    reset = 1'b0;
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    // Pin the reference model to hand-computed results.
    m = model(12, 18, 6);
    chk("model_basic", {m.n, m.d, m.l, 7'd0, m.e}, {8'd2, 8'd3, 16'd36, 8'd0});
    m = model(0, 0, 0);
    chk("model_zero", {m.n, m.d, m.l, 7'd0, m.e}, {8'd0, 8'd0, 16'd0, 8'd1});
    m = model(255, 254, 1);
    chk("model_max", {m.n, m.d, m.l, 7'd0, m.e}, {8'd255, 8'd254, 16'd64770, 8'd0});
    m = model(12, 18, 5);
    chk("model_badgcd", {m.n, m.d, m.l, 7'd0, m.e}, {8'd2, 8'd3, 16'd36, 8'd1});

    send(12, 18, 6, 0);
    send(0, 5, 5, 0);
    send(0, 0, 0, 0);
    send(255, 255, 255, 0);
    send(255, 254, 1, 0);
    send(12, 18, 5, 0);
    send(7, 9, 1, 10);
    send(100, 75, 25, 0);

    start(12, 18, 6);
    reset_after(3);
    send(12, 18, 6, 0);
    start(255, 254, 1);
    reset_after(12);
    send(40, 24, 8, 2);

    for (int i = 0; i < 60; i++) begin
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      r = $urandom_range(0, 9);
      if (r < 7)      g = true_gcd(a, b);
      else if (r < 9) g = $urandom_range(1, 255);
      else            g = 0;
      send(a, b, g, $urandom_range(0, 3));
    end

    repeat (3) @(posedge clock);
    #1;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
